// File: rtl/tlb_arb_pkg.sv
// Shared types and sizing for the TLB port arbiter: requester ids, the S1 lookup
// register layout and the TLB index format.
package tlb_arb_pkg;

    localparam int unsigned STARVE_LIMIT = 4;
    localparam int unsigned NREQ         = 3;
    localparam int unsigned STARVE_W     = 3;
    localparam int unsigned VPN_W        = 20;
    localparam int unsigned ASID_W       = 8;
    localparam int unsigned IDX_W        = 3;

    // Bit positions inside the one-hot grant vector
    localparam int unsigned GNT_IF  = 0;
    localparam int unsigned GNT_MEM = 1;
    localparam int unsigned GNT_PRB = 2;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        IF   = 2'd1,
        MEM  = 2'd2,
        PRB  = 2'd3
    } tlb_req_id_e;

    typedef struct packed {
        logic             p;
        logic [IDX_W-1:0] index;
    } Index_t;

    typedef struct packed {
        tlb_req_id_e       id;
        logic [VPN_W-1:0]  vpn;
        logic [ASID_W-1:0] asid;
    } tlb_s1_t;

    // IF and MEM lookups belong to the pipeline and die on a flush; probes do not
    function automatic logic is_pipe_id(input tlb_req_id_e id);
        return (id == IF) || (id == MEM);
    endfunction

endpackage

// File: rtl/tlb_port_arbiter_if.sv
// Requester, lookup-block and result signals of the TLB port arbiter.
interface tlb_port_arbiter_if;
    import tlb_arb_pkg::*;

    logic              if_req;
    logic [VPN_W-1:0]  if_vpn;
    logic              if_gnt;
    logic              mem_req;
    logic [VPN_W-1:0]  mem_vpn;
    logic              mem_gnt;
    logic              prb_req;
    logic [VPN_W-1:0]  prb_vpn;
    logic              prb_gnt;
    logic [ASID_W-1:0] asid;
    logic              tlb_we;
    logic              flush;

    logic [VPN_W-1:0]  lk_vpn;
    logic [ASID_W-1:0] lk_asid;
    logic [VPN_W-1:0]  lk_ppn;
    logic              lk_hit;
    logic              lk_cached;
    logic              lk_dirty;
    logic              lk_valid;
    Index_t            lk_index;

    tlb_req_id_e       rsp_id;
    logic [VPN_W-1:0]  rsp_ppn;
    logic              rsp_hit;
    logic              rsp_cached;
    logic              rsp_dirty;
    logic              rsp_valid;
    Index_t            rsp_index;
    logic              if_rvalid;
    logic              mem_rvalid;
    logic              prb_done;

    // Requesters, CP0 and the lookup block together
    modport master (
        output if_req, if_vpn, mem_req, mem_vpn, prb_req, prb_vpn, asid, tlb_we, flush,
        output lk_ppn, lk_hit, lk_cached, lk_dirty, lk_valid, lk_index,
        input  if_gnt, mem_gnt, prb_gnt, lk_vpn, lk_asid,
        input  rsp_id, rsp_ppn, rsp_hit, rsp_cached, rsp_dirty, rsp_valid, rsp_index,
        input  if_rvalid, mem_rvalid, prb_done
    );

    modport slave (
        input  if_req, if_vpn, mem_req, mem_vpn, prb_req, prb_vpn, asid, tlb_we, flush,
        input  lk_ppn, lk_hit, lk_cached, lk_dirty, lk_valid, lk_index,
        output if_gnt, mem_gnt, prb_gnt, lk_vpn, lk_asid,
        output rsp_id, rsp_ppn, rsp_hit, rsp_cached, rsp_dirty, rsp_valid, rsp_index,
        output if_rvalid, mem_rvalid, prb_done
    );

endinterface

// File: rtl/tlb_arb_prio.sv
// Combinational one-hot grant (PRB > MEM > IF, IF promoted over MEM once starved)
// plus the saturating IF starvation counter.
module tlb_arb_prio
    import tlb_arb_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic            mem_req,
    input  logic            prb_req,
    input  logic            stall,
    input  logic            flush,
    output logic [NREQ-1:0] gnt
);

    logic [STARVE_W-1:0] starve_cnt;
    logic                starving;

    assign starving = (starve_cnt >= STARVE_W'(STARVE_LIMIT));

    // stall blocks everyone; flush only blocks the pipeline requesters
    always_comb begin
        gnt = '0;
        if (!stall) begin
            if (prb_req) begin
                gnt[GNT_PRB] = 1'b1;
            end else if (!flush) begin
                if (starving && if_req) begin
                    gnt[GNT_IF] = 1'b1;
                end else if (mem_req) begin
                    gnt[GNT_MEM] = 1'b1;
                end else if (if_req) begin
                    gnt[GNT_IF] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!if_req || gnt[GNT_IF]) begin
            starve_cnt <= '0;
        end else if (!starving) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
        end
    end

endmodule

// File: rtl/tlb_port_arbiter.sv
// Arbitrates IF, MEM and CP0 probe lookups onto one TLB lookup port: grant, S1
// lookup register, S2 result register with per-requester result pulses.
module tlb_port_arbiter
    import tlb_arb_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    tlb_port_arbiter_if.slave   bus
);

    logic [NREQ-1:0] gnt;
    tlb_s1_t         s1_q;
    tlb_s1_t         s1_d;
    tlb_req_id_e     rsp_id_d;
    logic            kill;

    tlb_arb_prio u_prio (
        .clk     (clk),
        .rst     (rst),
        .if_req  (bus.if_req),
        .mem_req (bus.mem_req),
        .prb_req (bus.prb_req),
        .stall   (rst || bus.tlb_we),
        .flush   (bus.flush),
        .gnt     (gnt)
    );

    assign bus.if_gnt  = gnt[GNT_IF];
    assign bus.mem_gnt = gnt[GNT_MEM];
    assign bus.prb_gnt = gnt[GNT_PRB];

    assign bus.lk_vpn  = s1_q.vpn;
    assign bus.lk_asid = s1_q.asid;

    // A TLB write holds S1 for a replay next cycle; a flush still kills IF/MEM in S1
    always_comb begin
        s1_d     = s1_q;
        rsp_id_d = NONE;
        kill     = bus.flush && is_pipe_id(s1_q.id);
        if (kill) begin
            s1_d.id = NONE;
        end
        if (!bus.tlb_we) begin
            rsp_id_d = s1_d.id;
            s1_d.id  = NONE;
        end
        if (gnt[GNT_PRB]) begin
            s1_d = '{id: PRB, vpn: bus.prb_vpn, asid: bus.asid};
        end else if (gnt[GNT_MEM]) begin
            s1_d = '{id: MEM, vpn: bus.mem_vpn, asid: bus.asid};
        end else if (gnt[GNT_IF]) begin
            s1_d = '{id: IF, vpn: bus.if_vpn, asid: bus.asid};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q           <= '{id: NONE, vpn: '0, asid: '0};
            bus.rsp_id     <= NONE;
            bus.rsp_ppn    <= '0;
            bus.rsp_hit    <= 1'b0;
            bus.rsp_cached <= 1'b0;
            bus.rsp_dirty  <= 1'b0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_index  <= '{p: 1'b1, index: '0};
            bus.if_rvalid  <= 1'b0;
            bus.mem_rvalid <= 1'b0;
            bus.prb_done   <= 1'b0;
        end else begin
            s1_q           <= s1_d;
            bus.rsp_id     <= rsp_id_d;
            bus.if_rvalid  <= (rsp_id_d == IF);
            bus.mem_rvalid <= (rsp_id_d == MEM);
            bus.prb_done   <= (rsp_id_d == PRB);
            if (!bus.tlb_we) begin
                bus.rsp_ppn    <= bus.lk_ppn;
                bus.rsp_hit    <= bus.lk_hit;
                bus.rsp_cached <= bus.lk_cached;
                bus.rsp_dirty  <= bus.lk_dirty;
                bus.rsp_valid  <= bus.lk_valid;
                bus.rsp_index  <= bus.lk_index;
            end
        end
    end

endmodule

// File: tb/tb_tlb_port_arbiter.sv
// Bench for tlb_port_arbiter: directed scenarios with literal expectations, then
// random traffic checked every cycle against a transaction-level model.
module tb_tlb_port_arbiter;
    import tlb_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tlb_port_arbiter_if bus ();

    tlb_port_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        present;
        logic [19:0] vpn;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn;
        logic        c;
        logic        d;
        logic        v;
    } tent_t;

    typedef struct packed {
        logic        hit;
        logic [19:0] ppn;
        logic        c;
        logic        d;
        logic        v;
        Index_t      idx;
    } lres_t;

    typedef struct packed {
        tlb_req_id_e id;
        logic [19:0] vpn;
        logic [7:0]  asid;
    } txn_t;

    tent_t       tlb [8];
    logic [19:0] pool [4];

    // stimulus for the coming cycle
    logic        d_rst, d_if_req, d_mem_req, d_prb_req, d_we, d_flush;
    logic [19:0] d_if_vpn, d_mem_vpn, d_prb_vpn;
    logic [7:0]  d_asid;
    int          d_wr_idx;
    tent_t       d_wr_ent;

    // model: transaction waiting for its lookup, and what the result port must show
    txn_t        pend;
    tlb_req_id_e exp_id;
    lres_t       exp_res;
    bit          exp_rstvals;
    int          starve;
    bit          known;

    int n_vec  = 0;
    int n_fail = 0;
    int ncyc   = 0;

    function automatic lres_t lookup(input logic [19:0] vpn, input logic [7:0] a);
        lres_t r;
        r     = '0;
        r.idx = '{p: 1'b1, index: 3'd0};
        for (int i = 7; i >= 0; i--) begin
            if (tlb[i].present && tlb[i].vpn == vpn && (tlb[i].g || tlb[i].asid == a)) begin
                r.hit = 1'b1;
                r.ppn = tlb[i].pfn;
                r.c   = tlb[i].c;
                r.d   = tlb[i].d;
                r.v   = tlb[i].v;
                r.idx = '{p: 1'b0, index: 3'(i)};
            end
        end
        return r;
    endfunction

    function automatic tlb_req_id_e exp_grant();
        if (d_rst || d_we) return NONE;
        if (d_prb_req) return PRB;
        if (d_flush) return NONE;
        if (d_if_req && starve >= int'(STARVE_LIMIT)) return IF;
        if (d_mem_req) return MEM;
        if (d_if_req) return IF;
        return NONE;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    task automatic idle();
        d_rst = 0; d_if_req = 0; d_mem_req = 0; d_prb_req = 0; d_we = 0; d_flush = 0;
    endtask

    // One clock cycle: drive, model the lookup block, compare, advance the model
    task automatic step();
        tlb_req_id_e eg;
        lres_t       lk;
        @(negedge clk);
        rst         = d_rst;
        bus.if_req  = d_if_req;  bus.if_vpn  = d_if_vpn;
        bus.mem_req = d_mem_req; bus.mem_vpn = d_mem_vpn;
        bus.prb_req = d_prb_req; bus.prb_vpn = d_prb_vpn;
        bus.asid    = d_asid;
        bus.tlb_we  = d_we;
        bus.flush   = d_flush;
        if (d_we) tlb[d_wr_idx] = d_wr_ent;
        lk = lookup(bus.lk_vpn, bus.lk_asid);
        bus.lk_ppn = lk.ppn; bus.lk_hit = lk.hit; bus.lk_cached = lk.c;
        bus.lk_dirty = lk.d; bus.lk_valid = lk.v; bus.lk_index = lk.idx;
        #1;
        eg = exp_grant();
        if (known) begin
            chk("if_gnt",     32'(bus.if_gnt),     32'(eg == IF));
            chk("mem_gnt",    32'(bus.mem_gnt),    32'(eg == MEM));
            chk("prb_gnt",    32'(bus.prb_gnt),    32'(eg == PRB));
            chk("rsp_id",     32'(bus.rsp_id),     32'(exp_id));
            chk("if_rvalid",  32'(bus.if_rvalid),  32'(exp_id == IF));
            chk("mem_rvalid", 32'(bus.mem_rvalid), 32'(exp_id == MEM));
            chk("prb_done",   32'(bus.prb_done),   32'(exp_id == PRB));
            if (exp_id != NONE) begin
                chk("rsp_ppn",    32'(bus.rsp_ppn),    32'(exp_res.ppn));
                chk("rsp_hit",    32'(bus.rsp_hit),    32'(exp_res.hit));
                chk("rsp_cached", 32'(bus.rsp_cached), 32'(exp_res.c));
                chk("rsp_dirty",  32'(bus.rsp_dirty),  32'(exp_res.d));
                chk("rsp_valid",  32'(bus.rsp_valid),  32'(exp_res.v));
                chk("rsp_index",  32'(bus.rsp_index),  32'(exp_res.idx));
            end else if (exp_rstvals) begin
                chk("rst_ppn",   32'(bus.rsp_ppn),   32'h0);
                chk("rst_hit",   32'(bus.rsp_hit),   32'h0);
                chk("rst_index", 32'(bus.rsp_index), 32'h8);
            end
        end
        if (d_rst) begin
            pend        = '0;
            exp_id      = NONE;
            exp_rstvals = 1;
            starve      = 0;
            known       = 1;
        end else begin
            if (d_flush && (pend.id == IF || pend.id == MEM)) pend.id = NONE;
            if (d_we) begin
                exp_id = NONE;
            end else begin
                exp_id      = pend.id;
                exp_res     = lookup(pend.vpn, pend.asid);
                exp_rstvals = 0;
                pend.id     = NONE;
            end
            case (eg)
                PRB:     pend = '{id: PRB, vpn: d_prb_vpn, asid: d_asid};
                MEM:     pend = '{id: MEM, vpn: d_mem_vpn, asid: d_asid};
                IF:      pend = '{id: IF,  vpn: d_if_vpn,  asid: d_asid};
                default: ;
            endcase
            if (d_if_req && eg != IF) starve = (starve + 1 > int'(STARVE_LIMIT)) ? int'(STARVE_LIMIT) : starve + 1;
            else starve = 0;
        end
        ncyc++;
    endtask

    initial begin
        rst = 1'b1;
        bus.if_req = 0; bus.mem_req = 0; bus.prb_req = 0; bus.tlb_we = 0; bus.flush = 0;
        bus.if_vpn = 0; bus.mem_vpn = 0; bus.prb_vpn = 0; bus.asid = 0;
        bus.lk_ppn = 0; bus.lk_hit = 0; bus.lk_cached = 0; bus.lk_dirty = 0; bus.lk_valid = 0;
        bus.lk_index = '0;
        pend = '0; exp_id = NONE; exp_res = '0; exp_rstvals = 0; starve = 0; known = 0;
        pool[0] = 20'h00400; pool[1] = 20'h00401; pool[2] = 20'h00800; pool[3] = 20'h12345;
        for (int i = 0; i < 8; i++) tlb[i] = '0;
        tlb[0] = '{present: 1, vpn: 20'h00400, asid: 8'd1, g: 0, pfn: 20'h01234, c: 1, d: 0, v: 1};
        idle();
        d_if_vpn = 20'h00400; d_mem_vpn = 20'h00400; d_prb_vpn = 20'h00800; d_asid = 8'd1;
        d_wr_idx = 0; d_wr_ent = '0;

        // reset
        d_rst = 1; step(); step();
        d_rst = 0; step();
        chk("reset_if_rvalid", 32'(bus.if_rvalid), 32'h0);
        chk("reset_index_p",   32'(bus.rsp_index.p), 32'h1);
        chk("reset_rsp_ppn",   32'(bus.rsp_ppn), 32'h0);

        // single grant
        d_if_req = 1; step();
        chk("single_if_gnt", 32'(bus.if_gnt), 32'h1);
        d_if_req = 0; step(); step();
        chk("single_if_rvalid", 32'(bus.if_rvalid), 32'h1);
        chk("single_ppn", 32'(bus.rsp_ppn), 32'h01234);
        chk("single_hit", 32'(bus.rsp_hit), 32'h1);

        // three-way conflict, probe misses
        d_if_req = 1; d_mem_req = 1; d_prb_req = 1; step();
        chk("conf_prb_gnt_c0", 32'(bus.prb_gnt), 32'h1);
        d_prb_req = 0; step();
        chk("conf_mem_gnt_c1", 32'(bus.mem_gnt), 32'h1);
        d_mem_req = 0; step();
        chk("conf_if_gnt_c2", 32'(bus.if_gnt), 32'h1);
        chk("conf_prb_done_c2", 32'(bus.prb_done), 32'h1);
        chk("conf_prb_miss_p", 32'(bus.rsp_index.p), 32'h1);
        d_if_req = 0; step();
        chk("conf_mem_rvalid_c3", 32'(bus.mem_rvalid), 32'h1);
        step();
        chk("conf_if_rvalid_c4", 32'(bus.if_rvalid), 32'h1);

        // starvation
        d_if_req = 1; d_mem_req = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("starve_mem_gnt", 32'(bus.mem_gnt), 32'h1);
        end
        step();
        chk("starve_if_gnt_5th", 32'(bus.if_gnt), 32'h1);
        d_if_req = 0; step();
        chk("starve_mem_resume", 32'(bus.mem_gnt), 32'h1);
        idle(); step(); step(); step();

        // write replay
        d_mem_req = 1; step();
        chk("wr_mem_gnt", 32'(bus.mem_gnt), 32'h1);
        d_mem_req = 0; d_we = 1; d_wr_idx = 0;
        d_wr_ent = '{present: 1, vpn: 20'h00400, asid: 8'd1, g: 0, pfn: 20'h0ABCD, c: 1, d: 1, v: 1};
        step();
        d_we = 0; step();
        chk("wr_no_rvalid_c2", 32'(bus.mem_rvalid), 32'h0);
        step();
        chk("wr_mem_rvalid_c3", 32'(bus.mem_rvalid), 32'h1);
        chk("wr_new_ppn", 32'(bus.rsp_ppn), 32'h0ABCD);

        // flush kills IF, spares a probe
        d_if_req = 1; step();
        chk("fl_if_gnt", 32'(bus.if_gnt), 32'h1);
        d_if_req = 0; d_flush = 1; step();
        d_flush = 0; step();
        chk("fl_no_if_rvalid", 32'(bus.if_rvalid), 32'h0);
        d_prb_req = 1; d_prb_vpn = 20'h00400; d_flush = 1; step();
        chk("fl_prb_gnt", 32'(bus.prb_gnt), 32'h1);
        d_prb_req = 0; step();
        d_flush = 0; step();
        chk("fl_prb_done", 32'(bus.prb_done), 32'h1);

        // reset with S1 occupied and the starve counter part-way up
        d_if_req = 1; d_mem_req = 1;
        step(); step(); step();
        d_rst = 1; step();
        d_rst = 0; step();
        chk("rst_mem_rvalid", 32'(bus.mem_rvalid), 32'h0);
        chk("rst_index_p", 32'(bus.rsp_index.p), 32'h1);
        step(); step(); step();
        chk("rst_starve_clr", 32'(bus.if_gnt), 32'h0);
        step();
        chk("rst_starve_if", 32'(bus.if_gnt), 32'h1);
        idle(); step(); step();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            if (!(d_if_req && !bus.if_gnt && $urandom_range(9) != 0)) begin
                d_if_req = ($urandom_range(3) != 0);
                d_if_vpn = pool[$urandom_range(3)];
            end
            if (!(d_prb_req && !bus.prb_gnt && $urandom_range(9) != 0)) begin
                d_prb_req = ($urandom_range(4) == 0);
                d_prb_vpn = pool[$urandom_range(3)];
            end
            d_mem_req = ($urandom_range(1) == 0);
            d_mem_vpn = pool[$urandom_range(3)];
            d_asid    = 8'($urandom_range(2, 1));
            d_we      = ($urandom_range(7) == 0);
            d_flush   = ($urandom_range(9) == 0);
            d_rst     = ($urandom_range(199) == 0);
            d_wr_idx  = $urandom_range(7);
            d_wr_ent  = '{present: ($urandom_range(3) != 0), vpn: pool[$urandom_range(3)],
                          asid: 8'($urandom_range(2, 1)), g: 1'($urandom_range(1)),
                          pfn: 20'($urandom), c: 1'($urandom_range(1)),
                          d: 1'($urandom_range(1)), v: 1'($urandom_range(1))};
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
